// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
// Debounces three board keys into single-cycle commands (mode cycle,
// threshold up, threshold down). Pending settings are applied to the display
// outputs only on a vertical-sync rising edge, so nothing changes mid-frame.
//
// Per-key FSM states:
//   state  | meaning
//   IDLE   | key released and settled, waiting for a press
//   ARM    | press seen, waiting for it to stay stable for the debounce time
//   HELD   | press accepted; key1/key2 emit auto-repeat pulses while held
//   REL    | release seen, waiting for it to stay stable before re-arming
module video_mode_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         REPEAT_CYCLES   = 12_500_000,
  parameter logic [7:0] TH_DEFAULT      = 8'd40,
  parameter logic [7:0] TH_STEP         = 8'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_n,
  input  logic       i_vs,
  output logic [1:0] mode_o,
  output logic [7:0] threshold_o,
  output logic       cfg_update,
  output logic [2:0] key_pulse_o
);

  // Both timers count down from a preloaded value; a zero count is terminal.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LOAD = RP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HELD = 2'd2,
    S_REL  = 2'd3
  } key_state_t;

  logic [2:0]      key_s1, key_s2;
  logic            vs_s1, vs_s2, vs_prev;
  logic            vs_rise;

  key_state_t      st_q   [3];
  key_state_t      st_d   [3];
  logic [DB_W-1:0] cnt_q  [3];
  logic [DB_W-1:0] cnt_d  [3];
  logic [RP_W-1:0] rpt_q  [3];
  logic [RP_W-1:0] rpt_d  [3];
  logic [2:0]      pulse_d;

  logic [1:0]      pending_mode;
  logic [7:0]      pending_th;

  assign vs_rise = vs_s2 & ~vs_prev;

  // Two-flop synchronisers for the asynchronous keys and vsync, plus vsync history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1  <= 3'b111;
      key_s2  <= 3'b111;
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      key_s1  <= key_n;
      key_s2  <= key_s1;
      vs_s1   <= i_vs;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
    end
  end

  // Key FSM state, timers and registered command pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        st_q[k]  <= S_IDLE;
        cnt_q[k] <= '0;
        rpt_q[k] <= '0;
      end
      key_pulse_o <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
        rpt_q[k] <= rpt_d[k];
      end
      key_pulse_o <= pulse_d;
    end
  end

  // Key FSM next state; a synced level of 0 means pressed.
  always_comb begin
    pulse_d = 3'b000;
    for (int k = 0; k < 3; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
      rpt_d[k] = rpt_q[k];
      case (st_q[k])
        S_IDLE: begin
          if (!key_s2[k]) begin
            st_d[k]  = S_ARM;
            cnt_d[k] = DB_LOAD;
          end
        end
        S_ARM: begin
          if (key_s2[k]) begin
            st_d[k] = S_IDLE;
          end else if (cnt_q[k] == '0) begin
            st_d[k]    = S_HELD;
            pulse_d[k] = 1'b1;
            rpt_d[k]   = RP_LOAD;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        S_HELD: begin
          if (key_s2[k]) begin
            st_d[k]  = S_REL;
            cnt_d[k] = DB_LOAD;
          end else if (k != 0 && REPEAT_CYCLES > 0) begin
            if (rpt_q[k] == '0) begin
              pulse_d[k] = 1'b1;
              rpt_d[k]   = RP_LOAD;
            end else begin
              rpt_d[k] = rpt_q[k] - 1'b1;
            end
          end
        end
        S_REL: begin
          // A press while settling is treated as release bounce: no new command.
          if (!key_s2[k]) begin
            st_d[k]  = S_HELD;
            rpt_d[k] = RP_LOAD;
          end else if (cnt_q[k] == '0) begin
            st_d[k] = S_IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        default: st_d[k] = S_IDLE;
      endcase
    end
  end

  // Commands update the pending settings; opposing threshold commands cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_mode <= 2'd0;
      pending_th   <= TH_DEFAULT;
    end else begin
      if (key_pulse_o[0]) begin
        pending_mode <= (pending_mode == 2'd2) ? 2'd0 : pending_mode + 2'd1;
      end
      if (key_pulse_o[1] && !key_pulse_o[2]) begin
        pending_th <= (pending_th > 8'd255 - TH_STEP) ? 8'd255 : pending_th + TH_STEP;
      end else if (key_pulse_o[2] && !key_pulse_o[1]) begin
        pending_th <= (pending_th < TH_STEP) ? 8'd0 : pending_th - TH_STEP;
      end
    end
  end

  // Frame-start apply: copy pending settings to the outputs on vsync rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_o      <= 2'd0;
      threshold_o <= TH_DEFAULT;
      cfg_update  <= 1'b0;
    end else begin
      cfg_update <= vs_rise;
      if (vs_rise) begin
        mode_o      <= pending_mode;
        threshold_o <= pending_th;
      end
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Testbench for video_mode_ctrl: directed and randomised key presses and
// vsync frames, checked against an arithmetic model of the key rules.
module tb_video_mode_ctrl;

  localparam int D      = 4;
  localparam int R      = 8;
  localparam int TH_DEF = 40;
  localparam int STEP   = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       i_vs  = 1'b0;
  logic [1:0] mode_o;
  logic [7:0] threshold_o;
  logic       cfg_update;
  logic [2:0] key_pulse_o;

  video_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .TH_DEFAULT     (8'd40),
    .TH_STEP        (8'd5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .i_vs       (i_vs),
    .mode_o     (mode_o),
    .threshold_o(threshold_o),
    .cfg_update (cfg_update),
    .key_pulse_o(key_pulse_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every key pulse and every cfg_update.
  int pq0[$];
  int pq1[$];
  int pq2[$];
  int uq[$];
  always @(negedge clk) begin
    if (key_pulse_o[0]) pq0.push_back(cyc);
    if (key_pulse_o[1]) pq1.push_back(cyc);
    if (key_pulse_o[2]) pq2.push_back(cyc);
    if (cfg_update)     uq.push_back(cyc);
  end

  int checks   = 0;
  int failures = 0;
  int m_mode   = 0;
  int m_th     = TH_DEF;

  function automatic int n_pulses(input int k);
    if (k == 0) return pq0.size();
    if (k == 1) return pq1.size();
    return pq2.size();
  endfunction

  function automatic int pulse_at(input int k, input int i);
    if (i < 0 || i >= n_pulses(k)) return -1;
    if (k == 0) return pq0[i];
    if (k == 1) return pq1[i];
    return pq2[i];
  endfunction

  // A press held for len clock edges is accepted if the synced level stays
  // low for the whole debounce window; key1/key2 then repeat every R cycles.
  function automatic int exp_pulses(input int k, input int len);
    if (len <= D) return 0;
    if (k == 0) return 1;
    return 1 + (len - D - 1) / R;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_model(input logic [2:0] mask, input int len);
    int n1, n2;
    if (mask[0]) m_mode = (m_mode + exp_pulses(0, len)) % 3;
    n1 = mask[1] ? exp_pulses(1, len) : 0;
    n2 = mask[2] ? exp_pulses(2, len) : 0;
    if (!(mask[1] && mask[2])) begin
      m_th = m_th + STEP * n1 - STEP * n2;
      if (m_th > 255) m_th = 255;
      if (m_th < 0)   m_th = 0;
    end
  endtask

  task automatic press(input string tag, input logic [2:0] mask, input int len);
    int c, n;
    int base[3];
    for (int k = 0; k < 3; k++) base[k] = n_pulses(k);
    @(negedge clk);
    c = cyc;
    key_n = ~mask;
    repeat (len) @(negedge clk);
    key_n = 3'b111;
    repeat (D + 8) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n = mask[k] ? exp_pulses(k, len) : 0;
      chk({tag, "_count"}, n_pulses(k) - base[k], n);
      if (n > 0) begin
        chk({tag, "_first"}, pulse_at(k, base[k]) - c, D + 3);
        chk({tag, "_last"}, pulse_at(k, base[k] + n - 1) - c, D + 3 + (n - 1) * R);
      end
    end
    apply_model(mask, len);
  endtask

  task automatic frame(input string tag);
    int u;
    u = uq.size();
    @(negedge clk);
    i_vs = 1'b1;
    repeat (6) @(negedge clk);
    i_vs = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_upd"}, uq.size() - u, 1);
    chk({tag, "_mode"}, mode_o, m_mode);
    chk({tag, "_th"}, threshold_o, m_th);
  endtask

  initial begin
    int u, c, old_mode, len;
    logic [2:0] mask;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mode", mode_o, 0);
    chk("rst_th", threshold_o, TH_DEF);
    chk("rst_upd", cfg_update, 0);
    chk("rst_pulse", key_pulse_o, 0);
    rst_n = 1'b1;

    // Idle with vsync low: nothing applied; then regular frames
    u = uq.size();
    repeat (30) @(negedge clk);
    chk("vs_low_hold", uq.size() - u, 0);
    frame("idle0");
    frame("idle1");
    frame("idle2");
    u = uq.size();
    @(negedge clk);
    i_vs = 1'b1;
    repeat (30) @(negedge clk);
    chk("vs_high_hold", uq.size() - u, 1);
    i_vs = 1'b0;
    repeat (4) @(negedge clk);

    // Bounce shorter than the debounce window
    press("bounce2", 3'b001, 2);
    press("bounce_d", 3'b001, D);
    frame("bounce_frame");

    // Mode cycling
    press("mode_a", 3'b001, 20);
    frame("mode_a_frame");
    press("mode_b", 3'b001, 20);
    frame("mode_b_frame");
    press("mode_c", 3'b001, 20);
    frame("mode_c_frame");

    // Threshold-up with auto-repeat
    press("th_up_hold", 3'b010, 40);
    frame("th_up_frame");

    // Coinciding up/down pulses cancel
    press("up_down", 3'b110, 20);
    frame("up_down_frame");

    // Saturate at 0
    for (int i = 0; i < 52; i++) press("th_dn", 3'b100, D + 1 + int'($urandom_range(0, 3)));
    frame("sat0_frame");

    // Saturate at 255
    press("th_up_long", 3'b010, 500);
    frame("sat255_frame");

    // Randomised presses
    for (int i = 0; i < 12; i++) begin
      mask = 3'($urandom_range(1, 7));
      len  = int'($urandom_range(1, 50));
      press("rand", mask, len);
      frame("rand_frame");
    end

    // Pending update in the same cycle as vsync rise
    old_mode = m_mode;
    u = uq.size();
    @(negedge clk);
    c = cyc;
    key_n = 3'b110;
    repeat (D + 1) @(negedge clk);
    i_vs = 1'b1;
    repeat (4) @(negedge clk);
    i_vs = 1'b0;
    repeat (20 - D - 5) @(negedge clk);
    key_n = 3'b111;
    repeat (D + 8) @(negedge clk);
    chk("coinc_upd", uq.size() - u, 1);
    chk("coinc_pulse_cyc", pulse_at(0, n_pulses(0) - 1) - c, D + 3);
    chk("coinc_upd_cyc", uq[uq.size() - 1] - c, D + 4);
    chk("coinc_old_mode", mode_o, old_mode);
    m_mode = (old_mode + 1) % 3;
    frame("coinc_next");

    // Reset while a key is held
    @(negedge clk);
    key_n = 3'b101;
    repeat (D + 6) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    key_n = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_mode", mode_o, 0);
    chk("mid_rst_th", threshold_o, TH_DEF);
    m_mode = 0;
    m_th   = TH_DEF;
    repeat (D + 8) @(negedge clk);
    frame("post_rst_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
